// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec execute-stage sequencer.
// Holds the ALU operation encodings, the datapath width, the FSM state
// encoding (also read by the debug tap, so values are fixed explicitly)
// and a small decode helper used by the sequencer.
package alu_exec_pkg;

    localparam int OP_CODE_W = 3;
    localparam int DATA_W    = 8;

    // ALU operation encodings; every other code is illegal.
    localparam logic [OP_CODE_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_CODE_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_CODE_W-1:0] OP_INC = 3'd2;
    localparam logic [OP_CODE_W-1:0] OP_DEC = 3'd3;

    // Sequencer state encoding, fixed so external observers can decode it.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    // Unary ops take only operand A, so the operand-B read is skipped.
    function automatic logic op_is_unary(input logic [OP_CODE_W-1:0] op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_exec_alu.sv
// Combinational 8-bit ALU used by alu_exec.
// Ports:
//   operation - op code (see alu_exec_pkg)
//   a, b      - operands (b ignored for increment/decrement)
//   result    - 8-bit result, modulo 2**8
//   carry     - carry-out; for subtract/decrement this is NOT borrow
//   zero      - result equals zero
//   illegal   - op code is not one of the defined operations
module alu_exec_alu
    import alu_exec_pkg::*;
#(
    parameter int OP_W = OP_CODE_W
) (
    input  logic [OP_W-1:0]   operation,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              illegal
);

    logic [DATA_W:0] sum_s;
    logic            illegal_s;

    // Nine-bit sum so the carry falls out of the top bit; subtraction and
    // decrement are done as two's-complement addition, giving NOT borrow.
    always_comb begin
        sum_s     = {(DATA_W+1){1'b0}};
        illegal_s = 1'b0;
        case (operation)
            OP_ADD:  sum_s = {1'b0, a} + {1'b0, b};
            OP_SUB:  sum_s = {1'b0, a} + {1'b0, ~b} + 9'd1;
            OP_INC:  sum_s = {1'b0, a} + 9'd1;
            OP_DEC:  sum_s = {1'b0, a} + 9'h0FF;
            default: illegal_s = 1'b1;
        endcase
    end

    assign result  = sum_s[DATA_W-1:0];
    assign carry   = sum_s[DATA_W];
    assign zero    = (sum_s[DATA_W-1:0] == 8'd0);
    assign illegal = illegal_s;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage sequencer: accepts one ALU instruction from the decoder,
// reads operand A (rd) and, for binary ops, operand B (rs) from the
// single-read-port register file, runs the alu, writes the result back to
// rd and owns the architectural {C,Z} flags.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   req_valid/req_ready       - instruction handshake (ready only in IDLE)
//   req_op/rd/rs/no_wb        - instruction fields, latched on accept
//   rf_rd_en/addr, rf_rd_data - register-file read; data valid 1 cycle later
//   rf_wr_en/addr/data        - register-file write (1-cycle pulse)
//   flags_load/flags_load_val - external flag write, wins over ALU update
//   flags_c, flags_z          - architectural flags
//   done                      - 1-cycle pulse in the writeback cycle
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int OP_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic [REG_ADDR_W-1:0] req_rs,
    input  logic                  req_no_wb,
    output logic                  rf_rd_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [7:0]            rf_rd_data,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [7:0]            rf_wr_data,
    input  logic                  flags_load,
    input  logic [1:0]            flags_load_val,
    output logic                  flags_c,
    output logic                  flags_z,
    output logic                  done
);

    state_e                  state_r;
    state_e                  next_state_s;
    logic                    ready_r;
    logic                    accept_s;
    logic                    rd_en_s;
    logic [REG_ADDR_W-1:0]   rd_addr_s;

    logic [OP_W-1:0]         op_r;
    logic [REG_ADDR_W-1:0]   rd_r;
    logic [REG_ADDR_W-1:0]   rs_r;
    logic                    no_wb_r;
    logic [DATA_W-1:0]       a_r;
    logic [DATA_W-1:0]       b_r;
    logic [DATA_W-1:0]       result_r;
    logic                    carry_r;
    logic                    zero_r;
    logic                    illegal_r;
    logic                    wr_en_r;
    logic                    done_r;
    logic                    flags_c_r;
    logic                    flags_z_r;

    logic [DATA_W-1:0]       alu_result_s;
    logic                    alu_carry_s;
    logic                    alu_zero_s;
    logic                    alu_illegal_s;

    assign accept_s = req_valid & ready_r;

    alu_exec_alu #(
        .OP_W (OP_W)
    ) u_alu (
        .operation (op_r),
        .a         (a_r),
        .b         (b_r),
        .result    (alu_result_s),
        .carry     (alu_carry_s),
        .zero      (alu_zero_s),
        .illegal   (alu_illegal_s)
    );

    // Next-state and read-port control. The read strobe must be combinational:
    // the register file returns data one cycle after the strobe, so operand A
    // is requested in the accept cycle and operand B while A is being captured.
    always_comb begin
        next_state_s = state_r;
        rd_en_s      = 1'b0;
        rd_addr_s    = {REG_ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_RD_A;
                    rd_en_s      = 1'b1;
                    rd_addr_s    = req_rd;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD_A: begin
                if (op_is_unary(op_r)) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_RD_B;
                    rd_en_s      = 1'b1;
                    rd_addr_s    = rs_r;
                end
            end
            ST_RD_B: next_state_s = ST_EXEC;
            ST_EXEC: next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register; ready mirrors "next state is IDLE" but stays low in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == ST_IDLE);
        end
    end

    // Instruction latch, operand capture and registered ALU result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r      <= {OP_W{1'b0}};
            rd_r      <= {REG_ADDR_W{1'b0}};
            rs_r      <= {REG_ADDR_W{1'b0}};
            no_wb_r   <= 1'b0;
            a_r       <= 8'd0;
            b_r       <= 8'd0;
            result_r  <= 8'd0;
            carry_r   <= 1'b0;
            zero_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r    <= req_op;
                rd_r    <= req_rd;
                rs_r    <= req_rs;
                no_wb_r <= req_no_wb;
            end
            if (state_r == ST_RD_A) begin
                a_r <= rf_rd_data;
            end
            if (state_r == ST_RD_B) begin
                b_r <= rf_rd_data;
            end
            if (state_r == ST_EXEC) begin
                result_r  <= alu_result_s;
                carry_r   <= alu_carry_s;
                zero_r    <= alu_zero_s;
                illegal_r <= alu_illegal_s;
            end
        end
    end

    // Writeback strobes, set on the EXEC->WB edge so they are high for WB only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            wr_en_r <= (state_r == ST_EXEC) && !no_wb_r && !alu_illegal_s;
            done_r  <= (state_r == ST_EXEC);
        end
    end

    // Architectural flags: an external load beats the ALU update in WB,
    // and illegal ops leave the flags untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_c_r <= 1'b0;
            flags_z_r <= 1'b0;
        end else if (flags_load) begin
            flags_c_r <= flags_load_val[1];
            flags_z_r <= flags_load_val[0];
        end else if ((state_r == ST_WB) && !illegal_r) begin
            flags_c_r <= carry_r;
            flags_z_r <= zero_r;
        end
    end

    assign req_ready  = ready_r;
    assign rf_rd_en   = rd_en_s;
    assign rf_rd_addr = rd_addr_s;
    assign rf_wr_en   = wr_en_r;
    assign rf_wr_addr = rd_r;
    assign rf_wr_data = result_r;
    assign flags_c    = flags_c_r;
    assign flags_z    = flags_z_r;
    assign done       = done_r;

endmodule
